parking_gate_arbiter: RTL and testbench
=======================================

Name: parking_gate_arbiter

Overview:
Controller for a single shared barrier lane used by both entering and exiting cars. It arbitrates entry/exit requests and sequences the gate through open, pass-wait and close phases. It owns the occupancy count and the full flag, and enforces capacity, pass timeout and close-settling time. It sits between the lane sensors and the gate actuator.

Parameters:
CAPACITY, 10, number of parking slots; entry is refused when count == CAPACITY
CNT_W, 8, width of occupancy count; CAPACITY must be < 2**CNT_W
TIMEOUT, 64, cycles in PASS without pass_done before abort (>= 1)
CLOSE_CYCLES, 4, cycles spent in CLOSING before the next grant (>= 1)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
entry_req  in  1  level; car waiting at entry side
exit_req  in  1  level; car waiting at exit side
pass_done  in  1  single-cycle pulse; car has cleared the barrier
gate_open  out  1  barrier raise command
grant_in  out  1  entry lane currently granted
grant_out  out  1  exit lane currently granted
count  out  CNT_W  current occupancy
full  out  1  count == CAPACITY
deny_in  out  1  entry request refused this cycle (lot full)
timeout  out  1  one-cycle pulse; pass aborted

Behaviour:
- All outputs are registered. On reset: state=IDLE, count=0, full=0, gate_open=0, grant_in=0, grant_out=0, deny_in=0, timeout=0, priority=exit.
- FSM states: IDLE, PASS, CLOSING.
- IDLE:
  - entry is eligible when entry_req && !full.
  - exit is eligible when exit_req && count > 0. An exit_req with count == 0 is ignored.
  - One eligible requester: grant it.
  - Both eligible: grant the side holding priority. Priority then flips to the other side (round-robin).
  - On the grant edge: state -> PASS, gate_open=1, and the matching grant_* = 1. Visible the cycle after the request is sampled (latency 1).
  - deny_in = 1 (registered) while in IDLE with entry_req && full; 0 otherwise.
- PASS:
  - Grant and gate_open are held; requests are ignored.
  - The timer counts cycles in PASS.
  - pass_done while grant_in: count+1. pass_done while grant_out: count-1. Either way -> CLOSING.
  - Timer reaches TIMEOUT with no pass_done: timeout pulses 1 cycle, count is unchanged, -> CLOSING.
  - pass_done on the same cycle the timer expires counts as a valid pass; no timeout pulse.
- CLOSING:
  - gate_open=0, grants=0.
  - Lasts exactly CLOSE_CYCLES cycles, then -> IDLE.
  - pass_done here is ignored.
- Count arithmetic is unsigned CNT_W bits.
  - Count never exceeds CAPACITY and never underflows; the eligibility rules guarantee this.
  - full is updated on the same edge as count.
- pass_done in IDLE is ignored.
- Reset asserted mid-PASS: gate drops immediately (asynchronous) and count clears to 0.

Test Plan:
1. Reset, then entry_req=1 for 1 cycle -> next cycle gate_open=1, grant_in=1. Then pass_done -> count=1. gate_open=0 for 4 cycles, then back in IDLE.
2. entry_req and exit_req asserted together with count=3 (priority=exit after reset) -> grant_out first, count=2. After CLOSING with both still high -> grant_in, count=3.
3. Fill to count=10 -> full=1. entry_req held -> deny_in=1, no grant. exit pass -> count=9, full=0, deny_in=0. Next entry is granted.
4. exit_req with count=0 -> no grant, gate_open stays 0, count stays 0.
5. Grant entry and withhold pass_done for 64 cycles -> timeout pulses 1 cycle, count unchanged, CLOSING for 4 cycles. Also pass_done exactly on cycle 64 -> count+1 with no timeout.
6. Assert reset asynchronously mid-PASS with count=5 -> gate_open, grant_in and count drop to 0 before the next clock edge. After release, the FSM is in IDLE.

Source files
------------

// File: rtl/parking_gate_arbiter_if.sv
// Lane bundle between sensors/actuator side (master) and arbiter (slave).
// Requests and pass_done flow master->slave; gate/grant/status flow back.
interface parking_gate_arbiter_if #(
  parameter int CNT_W = 8
);
  logic             entry_req;
  logic             exit_req;
  logic             pass_done;
  logic             gate_open;
  logic             grant_in;
  logic             grant_out;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             deny_in;
  logic             timeout;

  modport master (
    output entry_req,
    output exit_req,
    output pass_done,
    input  gate_open,
    input  grant_in,
    input  grant_out,
    input  count,
    input  full,
    input  deny_in,
    input  timeout
  );

  modport slave (
    input  entry_req,
    input  exit_req,
    input  pass_done,
    output gate_open,
    output grant_in,
    output grant_out,
    output count,
    output full,
    output deny_in,
    output timeout
  );
endinterface

// File: rtl/parking_gate_arbiter.sv
// Shared-lane barrier arbiter: entry/exit round-robin, occupancy, timeout.
// Ports: clk, reset (async high), bus (slave: reqs in, gate/status out).
module parking_gate_arbiter #(
  parameter int CAPACITY     = 10,
  parameter int CNT_W        = 8,
  parameter int TIMEOUT      = 64,
  parameter int CLOSE_CYCLES = 4
) (
  input logic                   clk,
  input logic                   reset,
  parking_gate_arbiter_if.slave bus
);

  localparam int TMAX =
    (TIMEOUT > CLOSE_CYCLES) ? TIMEOUT : CLOSE_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] C_LAST = TW'(CLOSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    CLOSING
  } state_t;

  state_t           state;
  logic [TW-1:0]    timer;
  logic             prio_exit;
  logic [CNT_W-1:0] cnt;
  logic             full_q;
  logic             gate_q;
  logic             gin_q;
  logic             gout_q;
  logic             deny_q;
  logic             tmo_q;

  logic             in_ok;
  logic             out_ok;
  logic             pick_out;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_dec;

  always_comb begin
    in_ok    = bus.entry_req && !full_q;
    out_ok   = bus.exit_req && (cnt != '0);
    pick_out = out_ok && (!in_ok || prio_exit);
    cnt_inc  = cnt + ONE;
    cnt_dec  = cnt - ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      prio_exit <= 1'b1;
      cnt       <= '0;
      full_q    <= 1'b0;
      gate_q    <= 1'b0;
      gin_q     <= 1'b0;
      gout_q    <= 1'b0;
      deny_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_q  <= 1'b0;
      deny_q <= 1'b0;
      unique case (state)
        IDLE: begin
          deny_q <= bus.entry_req && full_q;
          timer  <= '0;
          if (in_ok || out_ok) begin
            state  <= PASS;
            gate_q <= 1'b1;
            gin_q  <= !pick_out;
            gout_q <= pick_out;
            // round-robin only moves on contention
            if (in_ok && out_ok)
              prio_exit <= !prio_exit;
          end
        end
        PASS: begin
          if (bus.pass_done || timer == T_LAST) begin
            state  <= CLOSING;
            timer  <= '0;
            gate_q <= 1'b0;
            gin_q  <= 1'b0;
            gout_q <= 1'b0;
            // a pass on the expiry cycle still counts
            if (bus.pass_done) begin
              if (gin_q) begin
                cnt    <= cnt_inc;
                full_q <= (cnt_inc == CAP);
              end else begin
                cnt    <= cnt_dec;
                full_q <= 1'b0;
              end
            end else begin
              tmo_q <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CLOSING: begin
          if (timer == C_LAST) begin
            state <= IDLE;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  assign bus.gate_open = gate_q;
  assign bus.grant_in  = gin_q;
  assign bus.grant_out = gout_q;
  assign bus.count     = cnt;
  assign bus.full      = full_q;
  assign bus.deny_in   = deny_q;
  assign bus.timeout   = tmo_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Randomized bench for parking_gate_arbiter with a transaction model.
// Expected pass/deny events are queued and checked by a monitor.
module tb_parking_gate_arbiter;

  localparam int CAP = 10;
  localparam int TMO = 64;
  localparam int CLS = 4;

  typedef struct {
    bit is_deny;
    bit side_exit;
    int occ;
    bit full;
    bit tmo;
  } exp_t;

  logic clk;
  logic reset;

  parking_gate_arbiter_if #(.CNT_W(8)) bus ();

  parking_gate_arbiter #(
    .CAPACITY    (CAP),
    .CNT_W       (8),
    .TIMEOUT     (TMO),
    .CLOSE_CYCLES(CLS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   occ;
  bit   prio_exit;
  int   wait_left;
  bit   mon_en;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               name, act, req, $time);
    end
  endtask

  // monitor: compares DUT events against queued expectations
  initial begin
    bit   pg, pgi, pgo, pd, fell;
    exp_t e;
    pg = 0; pgi = 0; pgo = 0; pd = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        fell = pg && !bus.gate_open;
        chk("grant_onehot",
            int'(bus.grant_in && bus.grant_out), 0);
        chk("gate_vs_grant", bus.gate_open,
            bus.grant_in | bus.grant_out);
        chk("full_flag", bus.full, int'(bus.count == CAP));
        if (bus.deny_in && !pd) begin
          if (q.size() == 0) begin
            chk("deny_unexpected", 1, 0);
          end else begin
            e = q.pop_front();
            chk("deny_type", e.is_deny, 1);
            chk("deny_count", bus.count, e.occ);
          end
        end
        if (fell) begin
          if (q.size() == 0) begin
            chk("pass_unexpected", 1, 0);
          end else begin
            e = q.pop_front();
            chk("pass_type", e.is_deny, 0);
            chk("pass_side_exit", pgo, e.side_exit);
            chk("pass_side_in", pgi, !e.side_exit);
            chk("pass_count", bus.count, e.occ);
            chk("pass_full", bus.full, e.full);
            chk("pass_timeout", bus.timeout, e.tmo);
          end
        end else begin
          chk("timeout_idle", bus.timeout, 0);
        end
      end
      pg  = bus.gate_open;
      pgi = bus.grant_in;
      pgo = bus.grant_out;
      pd  = bus.deny_in;
    end
  end

  // d: PASS cycle carrying pass_done; d > TMO means withheld
  task automatic txn(bit e, bit x, int d);
    bit   fullm, eok, xok, gr, sx;
    exp_t r;
    int   lat, n;
    fullm = (occ == CAP);
    eok = e && !fullm;
    xok = x && (occ > 0);
    gr  = eok || xok;
    sx  = xok && (!eok || prio_exit);
    if (eok && xok) prio_exit = !prio_exit;
    if (e && fullm) begin
      r = '{1'b1, 1'b0, occ, fullm, 1'b0};
      q.push_back(r);
    end
    if (gr) begin
      if (d <= TMO) occ += sx ? -1 : 1;
      r = '{1'b0, sx, occ, (occ == CAP), (d > TMO)};
      q.push_back(r);
    end
    lat = (wait_left > 1) ? wait_left : 1;
    bus.entry_req = e;
    bus.exit_req  = x;
    if (!gr) begin
      for (int i = 0; i < CLS + 3; i++) begin
        @(negedge clk);
        chk("no_grant_gate", bus.gate_open, 0);
      end
      bus.entry_req = 0;
      bus.exit_req  = 0;
      @(negedge clk);
      wait_left = 0;
    end else begin
      n = 0;
      while (!bus.gate_open && n < lat + 3) begin
        @(negedge clk);
        n++;
      end
      chk("grant_latency", n, lat);
      bus.entry_req = 0;
      bus.exit_req  = 0;
      if (bus.gate_open) begin
        n = 0;
        bus.pass_done = (d == 1);
        while (bus.gate_open && n < TMO + 4) begin
          @(negedge clk);
          n++;
          bus.pass_done = (n == d - 1);
        end
        bus.pass_done = 0;
        chk("pass_length", n, (d <= TMO) ? d : TMO);
      end
      wait_left = CLS + 1;
    end
  endtask

  // idle gap; stray pass_done here must be ignored
  task automatic gap(int g);
    for (int i = 0; i < g; i++) begin
      bus.pass_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      wait_left = (wait_left > 0) ? wait_left - 1 : 0;
    end
    bus.pass_done = 0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int pe, px, rr, d, n;
    bit e, x;
    reset = 1'b1;
    bus.entry_req = 0;
    bus.exit_req  = 0;
    bus.pass_done = 0;
    mon_en = 0;
    occ = 0;
    prio_exit = 1;
    wait_left = 0;
    repeat (3) @(negedge clk);
    chk("rst_gate", bus.gate_open, 0);
    chk("rst_gin", bus.grant_in, 0);
    chk("rst_gout", bus.grant_out, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_deny", bus.deny_in, 0);
    chk("rst_timeout", bus.timeout, 0);
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1;

    for (int t = 0; t < 180; t++) begin
      if (t < 40) begin pe = 90; px = 15; end
      else if (t < 100) begin pe = 40; px = 80; end
      else begin pe = 60; px = 60; end
      e = ($urandom_range(0, 99) < pe);
      x = ($urandom_range(0, 99) < px);
      if (!e && !x) e = 1;
      rr = $urandom_range(0, 19);
      if (rr == 0) d = TMO + 100;
      else if (rr == 1) d = TMO;
      else if (rr == 2) d = TMO - 1;
      else d = $urandom_range(1, 8);
      txn(e, x, d);
      gap($urandom_range(0, 6));
    end

    // asynchronous reset in the middle of a pass
    gap(CLS + 2);
    mon_en = 0;
    bus.entry_req = (occ < CAP);
    bus.exit_req  = !(occ < CAP);
    n = 0;
    while (!bus.gate_open && n < 3) begin
      @(negedge clk);
      n++;
    end
    chk("rst_setup_grant", bus.gate_open, 1);
    bus.entry_req = 0;
    bus.exit_req  = 0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_gate", bus.gate_open, 0);
    chk("arst_gin", bus.grant_in, 0);
    chk("arst_gout", bus.grant_out, 0);
    chk("arst_count", bus.count, 0);
    chk("arst_full", bus.full, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    occ = 0;
    prio_exit = 1;
    wait_left = 0;
    mon_en = 1;
    txn(1, 1, 3);
    txn(1, 1, 2);
    txn(1, 1, 5);
    gap(CLS + 2);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
